// File: rtl/intr_priority_ctrl.sv
// Prioritised interrupt controller: edge/level capture, masked priority
// arbitration with threshold, and an IDLE/PRESENT/SERVICE handshake with the CPU.
module intr_priority_ctrl #(
  parameter int NCH    = 4,
  parameter int PRIO_W = 4,
  parameter int IDW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        irq_in,
  input  logic [NCH-1:0]        edge_mode,
  input  logic [NCH-1:0]        mask,
  input  logic [NCH*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]     threshold,
  input  logic                  iack,
  input  logic                  eoi,
  output logic                  intr,
  output logic [IDW-1:0]        intr_id,
  output logic [PRIO_W-1:0]     intr_prio,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [NCH-1:0]      pending_r, pending_nxt_s;
  logic [NCH-1:0]      prev_r;
  logic [NCH-1:0]      set_s;
  logic [NCH-1:0]      cand_s;
  logic                intr_r, intr_nxt_s;
  logic [IDW-1:0]      intr_id_r, intr_id_nxt_s;
  logic [PRIO_W-1:0]   intr_prio_r, intr_prio_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                ack_s;
  logic [PRIO_W-1:0]   prio_a_s [NCH];
  logic                win_found_s;
  logic [IDW-1:0]      win_id_s;
  logic [PRIO_W-1:0]   win_prio_s;
  logic                take_s;

  assign intr      = intr_r;
  assign intr_id   = intr_id_r;
  assign intr_prio = intr_prio_r;
  assign busy      = busy_r;

  // Ascending scan with strict '>' keeps the lowest index on equal priorities.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    win_prio_s  = '0;
    take_s      = 1'b0;
    set_s       = '0;
    cand_s      = '0;
    for (int i = 0; i < NCH; i++) begin
      prio_a_s[i] = prio[i*PRIO_W +: PRIO_W];
      set_s[i]    = irq_in[i] & (~edge_mode[i] | ~prev_r[i]);
      cand_s[i]   = pending_r[i] & mask[i] & (prio_a_s[i] > threshold);
      take_s      = cand_s[i] & (~win_found_s | (prio_a_s[i] > win_prio_s));
      win_id_s    = take_s ? IDW'(i) : win_id_s;
      win_prio_s  = take_s ? prio_a_s[i] : win_prio_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // Handshake state machine: next state and next registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    intr_nxt_s      = intr_r;
    intr_id_nxt_s   = intr_id_r;
    intr_prio_nxt_s = intr_prio_r;
    busy_nxt_s      = busy_r;
    ack_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s     = PRESENT;
          intr_nxt_s      = 1'b1;
          intr_id_nxt_s   = win_id_s;
          intr_prio_nxt_s = win_prio_s;
        end else begin
          intr_nxt_s      = 1'b0;
        end
      end
      PRESENT: begin
        if (iack) begin
          ack_s       = 1'b1;
          intr_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = SERVICE;
        end else if (!mask[intr_id_r] || (prio_a_s[intr_id_r] <= threshold)) begin
          intr_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          intr_nxt_s  = 1'b1;
        end
      end
      SERVICE: begin
        intr_nxt_s = 1'b0;
        if (eoi) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          busy_nxt_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        intr_nxt_s  = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // A fresh set event in the acknowledge cycle outranks the clear.
  always_comb begin
    pending_nxt_s = '0;
    for (int i = 0; i < NCH; i++) begin
      pending_nxt_s[i] = (pending_r[i] & ~(ack_s & (IDW'(i) == intr_id_r))) | set_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= '0;
      prev_r      <= '0;
      intr_r      <= 1'b0;
      intr_id_r   <= '0;
      intr_prio_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      prev_r      <= irq_in;
      intr_r      <= intr_nxt_s;
      intr_id_r   <= intr_id_nxt_s;
      intr_prio_r <= intr_prio_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Directed bench for intr_priority_ctrl: a behavioural reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_intr_priority_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic [3:0]  edge_mode;
  logic [3:0]  mask;
  logic [15:0] prio;
  logic [3:0]  threshold;
  logic        iack;
  logic        eoi;
  logic        intr;
  logic [1:0]  intr_id;
  logic [3:0]  intr_prio;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit en = 1'b0;

  // reference model state
  bit m_pend [4];
  bit m_prev [4];
  int m_phase;      // 0 waiting, 1 offered to CPU, 2 CPU handling
  bit m_intr;
  bit m_busy;
  int m_id;
  int m_prio;

  intr_priority_ctrl #(.NCH(4), .PRIO_W(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode), .mask(mask),
    .prio(prio), .threshold(threshold), .iack(iack), .eoi(eoi),
    .intr(intr), .intr_id(intr_id), .intr_prio(intr_prio), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int best;
    int bestp;
    int p [4];
    bit ev [4];
    for (int i = 0; i < 4; i++) begin
      p[i]  = int'(prio[i*4 +: 4]);
      ev[i] = irq_in[i] && (!edge_mode[i] || !m_prev[i]);
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_phase = 0; m_intr = 1'b0; m_busy = 1'b0; m_id = 0; m_prio = 0;
    end else begin
      if (m_phase == 0) begin
        best = -1; bestp = -1;
        for (int i = 0; i < 4; i++)
          if (m_pend[i] && mask[i] && p[i] > int'(threshold) && p[i] > bestp) begin
            best = i; bestp = p[i];
          end
        if (best >= 0) begin
          m_phase = 1; m_intr = 1'b1; m_id = best; m_prio = bestp;
        end
      end else if (m_phase == 1) begin
        if (iack) begin
          m_pend[m_id] = 1'b0; m_phase = 2; m_intr = 1'b0; m_busy = 1'b1;
        end else if (!mask[m_id] || p[m_id] <= int'(threshold)) begin
          m_phase = 0; m_intr = 1'b0;
        end
      end else if (eoi) begin
        m_phase = 0; m_busy = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) m_pend[i] = 1'b1;
        m_prev[i] = irq_in[i];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (en) begin
      chk("model_intr", intr, m_intr);
      chk("model_busy", busy, m_busy);
      chk("model_id",   intr_id, m_id);
      chk("model_prio", intr_prio, m_prio);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ack_and_end();
    iack = 1'b1; cyc(); iack = 1'b0;
    eoi  = 1'b1; cyc(); eoi  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; edge_mode = 4'b1111; mask = 4'b1111;
    prio = {4'd4, 4'd3, 4'd2, 4'd1}; threshold = 4'd0; iack = 1'b0; eoi = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    chk("reset_intr", intr, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_id", intr_id, 2'd0);
    chk("reset_prio", intr_prio, 4'd0);
    rst = 1'b0;

    // basic pulse, two-edge latency, stray iack/eoi while idle
    iack = 1'b1; eoi = 1'b1; cyc(); iack = 1'b0; eoi = 1'b0;
    chk("stray_ack_busy", busy, 1'b0);
    irq_in = 4'b0010; cyc(); irq_in = 4'b0000;
    chk("lat_not_yet", intr, 1'b0);
    cyc();
    chk("basic_intr", intr, 1'b1);
    chk("basic_id", intr_id, 2'd1);
    chk("basic_prio", intr_prio, 4'd2);
    iack = 1'b1; cyc(); iack = 1'b0;
    chk("basic_ack_intr", intr, 1'b0);
    chk("basic_ack_busy", busy, 1'b1);
    eoi = 1'b1; cyc(); eoi = 1'b0;
    chk("basic_eoi_busy", busy, 1'b0);
    cyc();
    chk("basic_quiet", intr, 1'b0);

    // equal priorities: lowest index first; iack+eoi together acts as iack
    prio = {4'd4, 4'd7, 4'd2, 4'd7};
    irq_in = 4'b0101; cyc(); irq_in = 4'b0000; cyc();
    chk("tie_id_first", intr_id, 2'd0);
    chk("tie_prio", intr_prio, 4'd7);
    iack = 1'b1; eoi = 1'b1; cyc(); iack = 1'b0; eoi = 1'b0;
    chk("ack_eoi_busy", busy, 1'b1);
    eoi = 1'b1; cyc(); eoi = 1'b0; cyc();
    chk("tie_second_intr", intr, 1'b1);
    chk("tie_second_id", intr_id, 2'd2);
    ack_and_end();

    // threshold is strict
    prio = {4'd4, 4'd3, 4'd5, 4'd1}; threshold = 4'd5;
    irq_in = 4'b0010; cyc(); irq_in = 4'b0000; cyc(); cyc();
    chk("thr_blocked", intr, 1'b0);
    threshold = 4'd4; cyc();
    chk("thr_open_intr", intr, 1'b1);
    chk("thr_open_id", intr_id, 2'd1);
    ack_and_end();
    threshold = 4'd0; prio = {4'd4, 4'd3, 4'd2, 4'd1};

    // mask withdraws an offered interrupt, unmask re-presents it
    irq_in = 4'b1000; cyc(); irq_in = 4'b0000; cyc();
    chk("mask_pres_id", intr_id, 2'd3);
    mask = 4'b0111; cyc();
    chk("mask_withdraw", intr, 1'b0);
    cyc();
    chk("mask_hold_off", intr, 1'b0);
    mask = 4'b1111; cyc();
    chk("unmask_intr", intr, 1'b1);
    chk("unmask_id", intr_id, 2'd3);
    ack_and_end();

    // level channel held through iack/eoi re-pends
    edge_mode = 4'b1011; irq_in = 4'b0100; cyc(); cyc();
    chk("level_id", intr_id, 2'd2);
    ack_and_end();
    cyc();
    chk("level_repres_intr", intr, 1'b1);
    chk("level_repres_id", intr_id, 2'd2);
    irq_in = 4'b0000; ack_and_end(); cyc();
    chk("level_drop", intr, 1'b0);
    edge_mode = 4'b1111;

    // new edge in the acknowledge cycle is not lost
    irq_in = 4'b0001; cyc(); irq_in = 4'b0000; cyc();
    chk("edge_ack_first", intr_id, 2'd0);
    irq_in = 4'b0001; iack = 1'b1; cyc(); irq_in = 4'b0000; iack = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0; cyc();
    chk("edge_ack_again", intr, 1'b1);
    chk("edge_ack_id", intr_id, 2'd0);
    ack_and_end(); cyc();
    chk("edge_ack_done", intr, 1'b0);

    // reset during service discards everything
    irq_in = 4'b0001; cyc(); irq_in = 4'b0000; cyc();
    irq_in = 4'b0110; iack = 1'b1; cyc(); irq_in = 4'b0000; iack = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_intr", intr, 1'b0);
    cyc(); cyc();
    chk("rst_discard", intr, 1'b0);

    // irq held across reset release counts as an edge
    irq_in = 4'b1000; rst = 1'b1; cyc(); rst = 1'b0; cyc(); cyc();
    chk("post_rst_edge", intr, 1'b1);
    chk("post_rst_id", intr_id, 2'd3);
    irq_in = 4'b0000;

    // repeated edges while pending collapse to one event
    iack = 1'b1; cyc(); iack = 1'b0;
    irq_in = 4'b0010; cyc(); irq_in = 4'b0000; cyc();
    irq_in = 4'b0010; cyc(); irq_in = 4'b0000; cyc();
    eoi = 1'b1; cyc(); eoi = 1'b0; cyc();
    chk("collapse_id", intr_id, 2'd1);
    ack_and_end(); cyc(); cyc();
    chk("collapse_once", intr, 1'b0);

    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_priority_ctrl.md
INTR_PRIORITY_CTRL -- requirements
Module: intr_priority_ctrl

Interface
REQ-001 Parameter NCH, 4, number of interrupt channels (2..16) SHALL be supported.
REQ-002 Parameter PRIO_W, 4, per-channel priority field width SHALL be supported.
REQ-003 Parameter IDW, 2, channel-id width (must equal clog2(NCH)) SHALL be supported.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 irq_in  input  NCH  raw interrupt request lines.
REQ-007 edge_mode  input  NCH  per channel: 1 = rising-edge triggered, 0 = level triggered.
REQ-008 mask  input  NCH  per channel: 1 = enabled, 0 = blocked from selection.
REQ-009 prio  input  NCH*PRIO_W  channel i priority in bits [i*PRIO_W +: PRIO_W]; larger value = more urgent.
REQ-010 threshold  input  PRIO_W  a channel is eligible only if its prio is strictly greater than this value.
REQ-011 iack  input  1  CPU interrupt acknowledge, one-cycle pulse.
REQ-012 eoi  input  1  CPU end-of-interrupt, one-cycle pulse.
REQ-013 intr  output  1  interrupt request to the CPU, registered.
REQ-014 intr_id  output  IDW  id of the presented/in-service channel, registered.
REQ-015 intr_prio  output  PRIO_W  priority of the presented/in-service channel, registered.
REQ-016 busy  output  1  high while a channel is in service (between iack and eoi).

Function
REQ-017 Pending bit i SHALL set on the clock edge where irq_in[i]=1 and either edge_mode[i]=0, or edge_mode[i]=1 and the registered previous sample of irq_in[i]=0.
REQ-018 Pending bits SHALL capture regardless of mask; a pending masked channel SHALL become eligible as soon as it is unmasked.
REQ-019 Candidate = pending & mask & (prio > threshold); winner = highest prio; ties SHALL resolve to the lowest channel index.
REQ-020 FSM states IDLE, PRESENT, SERVICE.
REQ-021 IDLE: if a candidate exists, the controller SHALL latch intr_id/intr_prio, set intr=1 and move to PRESENT on the same edge.
REQ-022 Latency: irq_in first sampled high at edge k (in IDLE, no competitor) -> pending=1 after edge k -> intr=1 after edge k+1.
REQ-023 PRESENT: intr_id/intr_prio SHALL hold stable; a higher-priority candidate arriving SHALL NOT replace the presented channel.
REQ-024 PRESENT + iack: the controller SHALL clear pending[intr_id], drive intr=0, set busy=1 and move to SERVICE.
REQ-025 PRESENT, no iack, presented channel masked or its prio no longer > threshold: the controller SHALL withdraw (intr=0) and return to IDLE, keeping pending set.
REQ-026 SERVICE: intr SHALL remain 0 and intr_id/intr_prio SHALL hold; on eoi, busy=0 and return to IDLE; re-arbitration SHALL occur in IDLE on the next edge.
REQ-027 A new set event on a channel in the same cycle as its iack-clear SHALL win (pending stays 1; no event lost).
REQ-028 A level-mode channel still high after eoi SHALL re-pend and be re-presented.
REQ-029 iack outside PRESENT and eoi outside SERVICE SHALL be ignored; iack and eoi in the same PRESENT cycle SHALL act as iack only.
REQ-030 Repeated edges on an already-pending channel SHALL collapse into one pending event.

Reset
REQ-031 On rst=1 at a clock edge: pending=0, previous-sample register=0, state=IDLE, intr=0, intr_id=0, intr_prio=0, busy=0.
REQ-032 Reset mid-operation (PRESENT or SERVICE) SHALL discard all pending and in-service state; no acknowledge is required afterwards.
REQ-033 An irq_in held high across reset release on an edge-mode channel SHALL register as an edge on the first post-reset edge.

Verification
REQ-034 NCH=4, all edge, mask=1111, prio={4,3,2,1}(ch3..ch0), threshold=0; pulse irq_in[1] -> intr=1, intr_id=1, intr_prio=2 two edges later; iack -> intr=0, busy=1; eoi -> busy=0.
REQ-035 irq_in[0] and irq_in[2] rise same cycle, prio ch0=7, ch2=7 -> intr_id=0 first; after iack/eoi -> intr_id=2 presented.
REQ-036 threshold=5, ch1 prio=5 pulses -> intr stays 0; threshold set to 4 -> intr=1, intr_id=1.
REQ-037 ch3 presented, mask[3] cleared before iack -> intr=0 next edge, state IDLE; mask[3] restored -> ch3 re-presented.
REQ-038 ch2 level mode, irq_in[2] held high through iack and eoi -> ch2 re-presented one edge after eoi; new edge on edge-mode ch0 during iack cycle of ch0 -> ch0 presented again after eoi.
REQ-039 rst asserted during SERVICE with two channels pending -> all outputs 0 next edge, no interrupt presented until a new request.
